// File: rtl/melody_sequencer.sv
// melody_sequencer: walks a note table, timing notes in ticks and stepping a 128-entry wave-table address per note pitch.
// Latency: rom_addr is registered; note data is consumed one cycle after FETCH. Optional build macro MELODY_LOOP_EN repeats the melody.
// Backpressure: none; start/stop are level-sampled every cycle, and stop takes priority over start.
module melody_sequencer #(
  parameter int CLK_HZ    = 100000000,
  parameter int TICK_HZ   = 1000,
  parameter int NOTES     = 16,
  parameter int GAP_TICKS = 20
) (
  input  logic        CLK100MHZ,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_div,
  input  logic [11:0] rom_dur,
  output logic [6:0]  sample_address,
  output logic        tone_active,
  output logic        playing,
  output logic        done
);

  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int GW       = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  logic [7:0]    idx_q, idx_d;
  logic [15:0]   div_q, div_d;
  logic [15:0]   step_q, step_d;
  logic [11:0]   dur_q, dur_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [6:0]    sample_q, sample_d;
  logic          tone_q, tone_d;
  logic          done_q, done_d;
  logic          advance;
  logic          end_melody;

  assign tick           = (tick_cnt_q == TW'(TICK_DIV - 1));
  assign rom_addr       = idx_q;
  assign sample_address = sample_q;
  assign tone_active    = tone_q;
  assign done           = done_q;
  assign playing        = (state_q != S_IDLE);

  // Free-running duration tick, independent of the sequencer state.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else if (tick) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_q + TW'(1);
    end
  end

  // Sequencer state and per-note counters.
  always_ff @(posedge CLK100MHZ or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      div_q    <= '0;
      step_q   <= '0;
      dur_q    <= '0;
      gap_q    <= '0;
      sample_q <= '0;
      tone_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      div_q    <= div_d;
      step_q   <= step_d;
      dur_q    <= dur_d;
      gap_q    <= gap_d;
      sample_q <= sample_d;
      tone_q   <= tone_d;
      done_q   <= done_d;
    end
  end

  // Next-state: note fetch/load, pitch stepping, tick-timed duration and gap, end-of-melody handling.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    div_d      = div_q;
    step_d     = step_q;
    dur_d      = dur_q;
    gap_d      = gap_q;
    sample_d   = sample_q;
    tone_d     = tone_q;
    done_d     = 1'b0;
    advance    = 1'b0;
    end_melody = 1'b0;

    if (state_q != S_IDLE && stop) begin
      // Abort: silence and rewind without signalling completion.
      state_d  = S_IDLE;
      idx_d    = '0;
      sample_d = '0;
      tone_d   = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_d = S_FETCH;
            idx_d   = '0;
          end
        end
        S_FETCH: begin
          // rom_addr already holds the index; wait out the ROM read latency.
          state_d = S_LOAD;
        end
        S_LOAD: begin
          if (rom_dur == 12'd0) begin
            end_melody = 1'b1;
          end else begin
            div_d   = rom_div;
            dur_d   = rom_dur;
            step_d  = rom_div - 16'd1;
            tone_d  = (rom_div != 16'd0);
            state_d = S_PLAY;
          end
        end
        S_PLAY: begin
          // A rest (div 0) freezes the wave-table phase.
          if (div_q != 16'd0) begin
            if (step_q == 16'd0) begin
              step_d   = div_q - 16'd1;
              sample_d = sample_q + 7'd1;
            end else begin
              step_d = step_q - 16'd1;
            end
          end
          if (tick) begin
            dur_d = dur_q - 12'd1;
            if (dur_q == 12'd1) begin
              tone_d = 1'b0;
              if (GAP_TICKS == 0) begin
                advance = 1'b1;
              end else begin
                gap_d   = GW'(GAP_TICKS);
                state_d = S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          if (tick) begin
            gap_d = gap_q - GW'(1);
            if (gap_q == GW'(1)) begin
              advance = 1'b1;
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase

      if (advance) begin
        if (idx_q == 8'(NOTES - 1)) begin
          end_melody = 1'b1;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_FETCH;
        end
      end

      if (end_melody) begin
        done_d   = 1'b1;
        tone_d   = 1'b0;
        idx_d    = '0;
        sample_d = '0;
`ifdef MELODY_LOOP_EN
        state_d  = S_FETCH;
`else
        state_d  = S_IDLE;
`endif
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer: event scoreboard for melody_sequencer against a note-level reference model.
// Latency: expected events are queued per melody and consumed as the DUT produces them.
// Backpressure: none; the ROM model answers one cycle after rom_addr.
module tb_melody_sequencer;

  localparam int CLK_HZ    = 1000;
  localparam int TICK_HZ   = 100;
  localparam int NOTES     = 4;
  localparam int GAP_TICKS = 1;
  localparam int TPER      = CLK_HZ / TICK_HZ;

  localparam int EV_ADDR = 0;
  localparam int EV_TONE = 1;
  localparam int EV_CUT  = 2;
  localparam int EV_DONE = 3;
  localparam int OB_FALL = 4;

  typedef struct {
    int kind;
    int val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        stop;
  logic [7:0]  rom_addr;
  logic [15:0] rom_div;
  logic [11:0] rom_dur;
  logic [6:0]  sample_address;
  logic        tone_active;
  logic        playing;
  logic        done;

  int  tbl_div [NOTES];
  int  tbl_dur [NOTES];
  ev_t exp_q[$];
  int  n_cmp = 0;
  int  n_err = 0;

  int  prev_tone = 0;
  int  prev_addr = 0;
  int  prev_sample = 0;
  int  hi = 0;
  int  since = 0;

  always #5 clk = ~clk;

  melody_sequencer #(
    .CLK_HZ   (CLK_HZ),
    .TICK_HZ  (TICK_HZ),
    .NOTES    (NOTES),
    .GAP_TICKS(GAP_TICKS)
  ) dut (
    .CLK100MHZ     (clk),
    .rst_n         (rst_n),
    .start         (start),
    .stop          (stop),
    .rom_addr      (rom_addr),
    .rom_div       (rom_div),
    .rom_dur       (rom_dur),
    .sample_address(sample_address),
    .tone_active   (tone_active),
    .playing       (playing),
    .done          (done)
  );

  // Registered note ROM: data for rom_addr appears one cycle later.
  always @(posedge clk) begin
    if (int'(rom_addr) < NOTES) begin
      rom_div <= 16'(tbl_div[int'(rom_addr)]);
      rom_dur <= 12'(tbl_dur[int'(rom_addr)]);
    end else begin
      rom_div <= 16'd0;
      rom_dur <= 12'd0;
    end
  end

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  function automatic void push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.val  = v;
    exp_q.push_back(e);
  endfunction

  // Reference model: which notes are visited, which sound, and how the melody ends.
  function automatic void build_expected();
    int term;
    exp_q.delete();
    term = NOTES - 1;
    for (int i = 0; i < NOTES; i++) begin
      if (i > 0) push(EV_ADDR, i);
      if (tbl_dur[i] == 0) begin
        term = i;
        break;
      end
      if (tbl_div[i] != 0) push(EV_TONE, tbl_dur[i]);
    end
    if (term != 0) push(EV_ADDR, 0);
    push(EV_DONE, 0);
  endfunction

  task automatic observe(input int kind, input int val);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: kind %0d value %0d, expected no event", kind, val);
      return;
    end
    e = exp_q.pop_front();
    if (kind == OB_FALL) begin
      if (e.kind == EV_TONE) begin
        if (val <= (e.val - 1) * TPER || val > e.val * TPER) begin
          n_err++;
          $display("FAIL tone_length: got %0d cycles, expected %0d..%0d for dur %0d",
                   val, (e.val - 1) * TPER + 1, e.val * TPER, e.val);
        end
      end else if (e.kind != EV_CUT) begin
        n_err++;
        $display("FAIL event_order: got tone end, expected kind %0d value %0d", e.kind, e.val);
      end
    end else if (e.kind != kind || e.val != val) begin
      n_err++;
      $display("FAIL event_match: got kind %0d value %0d, expected kind %0d value %0d",
               kind, val, e.kind, e.val);
    end
  endtask

  // Monitor: turns output activity into events and checks wave-table stepping.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_tone   = 0;
      prev_addr   = 0;
      prev_sample = 0;
      hi          = 0;
      since       = 0;
    end else begin
      if (tone_active) hi++;
      if (prev_tone == 1 && !tone_active) begin
        observe(OB_FALL, hi);
        hi = 0;
      end
      if (int'(rom_addr) != prev_addr) observe(EV_ADDR, int'(rom_addr));
      if (done) observe(EV_DONE, 0);
      if (prev_tone == 1) since++;
      if (int'(sample_address) != prev_sample) begin
        if (!playing) begin
          chk("sample_clear", int'(sample_address), 0);
        end else if (prev_tone == 1) begin
          chk("sample_step", int'(sample_address), (prev_sample + 1) % 128);
          chk("step_interval", since, (prev_addr < NOTES) ? tbl_div[prev_addr] : -1);
        end else begin
          chk("sample_hold", int'(sample_address), prev_sample);
        end
        since = 0;
      end
      if (tone_active && prev_tone == 0) since = 0;
      prev_tone   = int'(tone_active);
      prev_addr   = int'(rom_addr);
      prev_sample = int'(sample_address);
    end
  end

  task automatic set_tbl(input int d0, input int u0, input int d1, input int u1,
                         input int d2, input int u2, input int d3, input int u3);
    tbl_div[0] = d0; tbl_dur[0] = u0;
    tbl_div[1] = d1; tbl_dur[1] = u1;
    tbl_div[2] = d2; tbl_dur[2] = u2;
    tbl_div[3] = d3; tbl_dur[3] = u3;
  endtask

  task automatic wait_note1_tone(input string name);
    int k;
    k = 0;
    while (!(rom_addr == 8'd1 && tone_active) && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk(name, int'(rom_addr == 8'd1 && tone_active), 1);
  endtask

  task automatic run_melody(input string name, input bit hold);
    int k;
    build_expected();
    repeat ($urandom_range(0, TPER - 1)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    chk({name, "_playing"}, int'(playing), 1);
    if (!hold) start = 1'b0;
    k = 0;
    while (!done && k < 3000) begin
      @(negedge clk);
      k++;
    end
    chk({name, "_done_seen"}, int'(done), 1);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk({name, "_idle"}, int'(playing), 0);
    chk({name, "_tone_off"}, int'(tone_active), 0);
    chk({name, "_sample0"}, int'(sample_address), 0);
    chk({name, "_addr0"}, int'(rom_addr), 0);
    chk({name, "_events_left"}, exp_q.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    stop  = 1'b0;
    set_tbl(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_addr", int'(rom_addr), 0);
    chk("rst_sample", int'(sample_address), 0);
    chk("rst_tone", int'(tone_active), 0);
    chk("rst_playing", int'(playing), 0);
    chk("rst_done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_after_reset", int'(playing), 0);

    // start and stop together in IDLE: stop wins, nothing plays.
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    chk("start_stop_idle", int'(playing), 0);

    // Pitched, fast, rest, then end marker.
    set_tbl(2, 3, 1, 2, 0, 1, 0, 0);
    run_melody("basic", 1'b0);

    // Slow pitch long enough to wrap the wave-table address.
    set_tbl(3, 45, 1, 2, 0, 1, 0, 0);
    run_melody("wrap", 1'b0);

    // No end marker: stops at the note-count limit; start held throughout.
    set_tbl(1, 1, 2, 2, 0, 1, 3, 1);
    run_melody("no_marker", 1'b1);

    // Marker on the very first entry.
    set_tbl(2, 0, 1, 1, 1, 1, 1, 1);
    run_melody("empty", 1'b0);

    // stop in the middle of note 1.
    set_tbl(2, 3, 3, 3, 1, 2, 0, 0);
    exp_q.delete();
    push(EV_TONE, 3);
    push(EV_ADDR, 1);
    push(EV_CUT, 0);
    push(EV_ADDR, 0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_note1_tone("stop_reach_note1");
    repeat (4) @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("stop_playing", int'(playing), 0);
    chk("stop_tone", int'(tone_active), 0);
    chk("stop_sample", int'(sample_address), 0);
    chk("stop_addr", int'(rom_addr), 0);
    repeat (40) @(negedge clk);
    chk("stop_events_left", exp_q.size(), 0);

    // Reset asserted during the gap after note 1, then replay.
    set_tbl(2, 2, 1, 2, 3, 1, 0, 0);
    exp_q.delete();
    push(EV_TONE, 2);
    push(EV_ADDR, 1);
    push(EV_TONE, 2);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_note1_tone("rst_reach_note1");
    for (int k = 0; k < 2000 && tone_active; k++) @(negedge clk);
    chk("rst_in_gap", int'(tone_active), 0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_addr", int'(rom_addr), 0);
    chk("midrst_sample", int'(sample_address), 0);
    chk("midrst_tone", int'(tone_active), 0);
    chk("midrst_playing", int'(playing), 0);
    chk("midrst_done", int'(done), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_events_left", exp_q.size(), 0);
    run_melody("replay", 1'b0);

    // Randomized tables.
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < NOTES; i++) begin
        tbl_div[i] = int'($urandom_range(0, 4));
        tbl_dur[i] = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 3));
      end
      run_melody("random", 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
